vec_normalize: RTL and testbench

Fixed-point vector normaliser for the Madgwick attitude datapath. It accepts an N-element signed vector, accumulates the sum of squares, and issues that sum to the external fast inverse-square-root unit as the initiating end of that unit's handshake. It then scales every element by the returned 1/sqrt and presents the unit vector downstream. It normalises both quaternion (N=4) and accelerometer/magnetometer (N=3) vectors.

---
 rtl/vec_normalize_if.sv | 32 +++
 rtl/vec_normalize.sv | 126 ++++++++++++
 tb/tb_vec_normalize.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vec_normalize_if.sv
// rtl/vec_normalize_if.sv - handshake bundle for the vector normaliser
interface vec_normalize_if #(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4,
    parameter int N           = 4
);
    localparam int W = INT_WIDTH + FRACT_WIDTH;

    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_vec;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_vec;
    logic           out_sat;
    logic           isq_valid;
    logic           isq_ready;
    logic [W-1:0]   isq_data;
    logic [W-1:0]   isq_result;
    logic           isq_result_valid;
    logic           isq_result_ready;

    modport slave (
        input  in_valid, in_vec, out_ready, isq_ready, isq_result, isq_result_valid,
        output in_ready, out_valid, out_vec, out_sat, isq_valid, isq_data, isq_result_ready
    );

    modport master (
        output in_valid, in_vec, out_ready, isq_ready, isq_result, isq_result_valid,
        input  in_ready, out_valid, out_vec, out_sat, isq_valid, isq_data, isq_result_ready
    );
endinterface

// File: rtl/vec_normalize.sv
// rtl/vec_normalize.sv - fixed-point vector normaliser driving an external 1/sqrt unit
module vec_normalize #(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4,
    parameter int N           = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    vec_normalize_if.slave bus
);
    localparam int W  = INT_WIDTH + FRACT_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQUARE,
        ST_REQUEST,
        ST_WAIT,
        ST_SCALE,
        ST_OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic [N*W-1:0]        vec_q;
    logic [N*W-1:0]        out_vec_q;
    logic [IW-1:0]         idx;
    logic [W-1:0]          acc;
    logic [W-1:0]          acc_nxt;
    logic [W-1:0]          res_q;
    logic [W-1:0]          scaled;
    logic                  sat;
    logic                  acc_ovf;
    logic                  pos_ovf;
    logic                  neg_ovf;
    logic                  last;
    logic signed [W-1:0]   elem;
    logic signed [2*W-1:0] sq;
    logic [2*W:0]          sum_wide;
    logic signed [2*W:0]   prod;
    logic signed [2*W:0]   prod_sh;

    assign elem = vec_q[int'(idx)*W +: W];
    assign last = (idx == IW'(N - 1));

    // Squares are never negative, so the shifted product adds straight into the unsigned sum.
    assign sq       = elem * elem;
    assign sum_wide = {1'b0, sq >>> FRACT_WIDTH} + {{(W + 1){1'b0}}, acc};
    assign acc_ovf  = |sum_wide[2*W:W];
    assign acc_nxt  = acc_ovf ? {W{1'b1}} : sum_wide[W-1:0];

    // res_q is zero-extended so a full-scale 1/sqrt is not read as negative.
    assign prod    = elem * $signed({1'b0, res_q});
    assign prod_sh = prod >>> FRACT_WIDTH;
    assign pos_ovf = !prod_sh[2*W] && (|prod_sh[2*W-1:W-1]);
    assign neg_ovf = prod_sh[2*W] && !(&prod_sh[2*W-1:W-1]);
    assign scaled  = pos_ovf ? {1'b0, {(W - 1){1'b1}}} :
                     neg_ovf ? {1'b1, {(W - 1){1'b0}}} : prod_sh[W-1:0];

    assign bus.in_ready         = rst_n && (state == ST_IDLE);
    assign bus.out_valid        = (state == ST_OUTPUT);
    assign bus.out_vec          = out_vec_q;
    assign bus.out_sat          = sat && (state == ST_OUTPUT);
    assign bus.isq_valid        = (state == ST_REQUEST);
    assign bus.isq_data         = acc;
    assign bus.isq_result_ready = (state == ST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.in_valid) state_nxt = ST_SQUARE;
            ST_SQUARE:  if (last) state_nxt = (acc_nxt == '0) ? ST_OUTPUT : ST_REQUEST;
            ST_REQUEST: if (bus.isq_ready) state_nxt = ST_WAIT;
            ST_WAIT:    if (bus.isq_result_valid) state_nxt = ST_SCALE;
            ST_SCALE:   if (last) state_nxt = ST_OUTPUT;
            ST_OUTPUT:  if (bus.out_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q     <= '0;
            out_vec_q <= '0;
            idx       <= '0;
            acc       <= '0;
            res_q     <= '0;
            sat       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        vec_q <= bus.in_vec;
                        acc   <= '0;
                        idx   <= '0;
                        sat   <= 1'b0;
                    end
                end
                ST_SQUARE: begin
                    acc <= acc_nxt;
                    if (acc_ovf) sat <= 1'b1;
                    idx <= last ? '0 : idx + IW'(1);
                    if (last && acc_nxt == '0) out_vec_q <= '0;
                end
                ST_WAIT: begin
                    if (bus.isq_result_valid) res_q <= bus.isq_result;
                end
                ST_SCALE: begin
                    out_vec_q[int'(idx)*W +: W] <= scaled;
                    if (pos_ovf || neg_ovf) sat <= 1'b1;
                    idx <= last ? '0 : idx + IW'(1);
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vec_normalize.sv
// tb/tb_vec_normalize.sv - directed bench for vec_normalize with an inline 1/sqrt responder
module tb_vec_normalize;
    localparam int IW = 12;
    localparam int FW = 4;
    localparam int N  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    vec_normalize_if #(.INT_WIDTH(IW), .FRACT_WIDTH(FW), .N(N)) bus ();

    vec_normalize #(.INT_WIDTH(IW), .FRACT_WIDTH(FW), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] vec);
        int n = 0;
        bus.in_vec   = vec;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            tick;
            n++;
        end
        check("accept_timeout", 64'(n < 20), 64'd1);
        tick;
        bus.in_valid = 1'b0;
    endtask

    task automatic serve_isq(input logic [15:0] exp_data, input logic [15:0] res, input int stall);
        int n = 0;
        while (!bus.isq_valid && n < 20) begin
            tick;
            n++;
        end
        check("isq_timeout", 64'(n < 20), 64'd1);
        check("isq_data", 64'(bus.isq_data), 64'(exp_data));
        for (int i = 0; i < stall; i++) begin
            tick;
            check("stall_valid", 64'(bus.isq_valid), 64'd1);
            check("stall_data", 64'(bus.isq_data), 64'(exp_data));
        end
        bus.isq_ready = 1'b1;
        tick;
        bus.isq_ready = 1'b0;
        check("wait_ready", 64'(bus.isq_result_ready), 64'd1);
        check("wait_data", 64'(bus.isq_data), 64'(exp_data));
        tick;
        bus.isq_result       = res;
        bus.isq_result_valid = 1'b1;
        tick;
        bus.isq_result_valid = 1'b0;
        bus.isq_result       = '0;
    endtask

    task automatic receive(input logic [63:0] exp_vec, input logic exp_sat, input int hold);
        int n = 0;
        while (!bus.out_valid && n < 40) begin
            tick;
            n++;
        end
        check("out_timeout", 64'(n < 40), 64'd1);
        check("out_vec", bus.out_vec, exp_vec);
        check("out_sat", 64'(bus.out_sat), 64'(exp_sat));
        check("busy_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            tick;
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_vec", bus.out_vec, exp_vec);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_vec    = '0;
        tick;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("post_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_vec"}, bus.out_vec, 64'd0);
        check({tag, "_out_sat"}, 64'(bus.out_sat), 64'd0);
        check({tag, "_isq_valid"}, 64'(bus.isq_valid), 64'd0);
        check({tag, "_isq_data"}, 64'(bus.isq_data), 64'd0);
        check({tag, "_isq_rdy"}, 64'(bus.isq_result_ready), 64'd0);
    endtask

    initial begin
        int n;
        bus.in_valid         = 1'b0;
        bus.in_vec           = '0;
        bus.out_ready        = 1'b0;
        bus.isq_ready        = 1'b0;
        bus.isq_result       = '0;
        bus.isq_result_valid = 1'b0;

        tick;
        tick;
        check_cleared("rst");
        rst_n = 1'b1;
        tick;
        check("rel_in_ready", 64'(bus.in_ready), 64'd1);

        // 1.0 along axis 0
        send(64'h0000_0000_0000_0010);
        serve_isq(16'h0010, 16'h0010, 0);
        receive(64'h0000_0000_0000_0010, 1'b0, 0);

        // -2.0 along axis 0
        send(64'h0000_0000_0000_FFE0);
        serve_isq(16'h0040, 16'h0008, 0);
        receive(64'h0000_0000_0000_FFF0, 1'b0, 0);

        // zero vector bypasses the 1/sqrt unit
        send(64'h0);
        for (int i = 1; i <= N; i++) begin
            tick;
            check("zero_isq_valid", 64'(bus.isq_valid), 64'd0);
            check("zero_latency", 64'(bus.out_valid), 64'(i == N));
        end
        receive(64'h0, 1'b0, 0);

        // accumulator overflow, stalled request, held output
        send({4{16'h0640}});
        serve_isq(16'hFFFF, 16'h0004, 7);
        receive({4{16'h0190}}, 1'b1, 5);

        // scale saturation in both directions
        send({16'h0000, 16'h0000, 16'hFF00, 16'h0100});
        serve_isq(16'h2000, 16'hFFFF, 0);
        receive({16'h0000, 16'h0000, 16'h8000, 16'h7FFF}, 1'b1, 0);

        // reset while waiting for the 1/sqrt result
        send(64'h0000_0000_0000_0010);
        n = 0;
        while (!bus.isq_valid && n < 20) begin
            tick;
            n++;
        end
        check("rw_isq_timeout", 64'(n < 20), 64'd1);
        bus.isq_ready = 1'b1;
        tick;
        bus.isq_ready = 1'b0;
        check("rw_in_wait", 64'(bus.isq_result_ready), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("mid");
        tick;
        rst_n = 1'b1;
        tick;
        bus.isq_result       = 16'h1234;
        bus.isq_result_valid = 1'b1;
        tick;
        bus.isq_result_valid = 1'b0;
        bus.isq_result       = '0;
        check("stale_out_valid", 64'(bus.out_valid), 64'd0);
        check("stale_in_ready", 64'(bus.in_ready), 64'd1);
        tick;
        check("stale_idle", 64'(bus.isq_valid | bus.out_valid), 64'd0);

        send(64'h0000_0000_0000_0010);
        serve_isq(16'h0010, 16'h0010, 0);
        receive(64'h0000_0000_0000_0010, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
